mac_chain_sys: RTL
==================

Name: mac_chain_sys

Overview:
- Parametrised systolic sum-of-products engine: P = sum over k of A[k]*B[k], with N signed multiply stages chained through registered cascade adders.
- Generalises the fixed quad 18x18/48 chain with parametrised width and depth, internal input skew so all taps of one sample align, a valid/sideband pipeline, and an optional frame accumulator with sticky overflow.
- Sits under the FIR/correlator datapaths, one instance per filter phase.

Parameters:
- N, 4, number of multiply stages (taps), 1..16.
- A_W, 18, signed width of each A operand.
- B_W, 18, signed width of each B operand.
- P_W, 48, signed width of cascade and output; elaboration error if P_W < A_W+B_W+clog2(N).
- SKEW, 1, 1 = delay stage k inputs by k cycles internally; 0 = caller pre-skews (raw systolic, as in earlier chains).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset of all registers.
- CE  in  1  clock enable for every register; low = whole pipeline holds.
- A  in  N*A_W  packed signed operands, stage k at [k*A_W +: A_W].
- B  in  N*B_W  packed signed operands, stage k at [k*B_W +: B_W].
- CLR  in  N  per-stage synchronous clear of stage k input registers (zeroes that tap's product).
- VLD_IN  in  1  sample valid.
- ACC_EN  in  1  1 = accumulate across frame; 0 = pass each sum.
- FIRST  in  1  first sample of frame (ACC_EN=1 only).
- LAST  in  1  last sample of frame (ACC_EN=1 only).
- P  out  P_W  signed result.
- P_VLD  out  1  one-cycle result strobe.
- OVF  out  1  sticky accumulator overflow for the frame, valid with P_VLD.

Behaviour:
- Reset: every register, including P, P_VLD and OVF, is 0. Async assert; release is synchronous to CLK.
- Stage k pipeline, all gated by CE:
  - skew delay of k cycles when SKEW=1;
  - input register, cleared when CLR[k] (skewed with the sample) is 1;
  - product register M = A*B, full A_W+B_W signed, sign-extended to P_W;
  - cascade register C_k = M_k + C_(k-1), where C_(-1) = 0.
- Chain latency: C_(N-1) for a sample is ready N+2 CE-cycles after the sample is presented.
- Sideband: VLD_IN, ACC_EN, FIRST and LAST are delayed N+2 CE-cycles alongside the data and land on the accumulator stage.
- Accumulator stage (1 cycle, total latency N+3), with aligned sideband:
  - valid=0: P, OVF hold; P_VLD=0.
  - ACC_EN=0: P<=SUM, OVF<=0, P_VLD=1.
  - ACC_EN=1, FIRST=1: P<=SUM, OVF<=0.
  - ACC_EN=1, FIRST=0: P<=P+SUM, wrapping two's complement; OVF|=signed overflow of that add.
  - ACC_EN=1: P_VLD=1 only when LAST=1.
  - FIRST and LAST together form a one-sample frame: P=SUM, P_VLD=1.
  - LAST with no prior FIRST accumulates onto the current P.
  - Invalid samples mid-frame are not added.
- P holds between strobes.
- CE low: no register changes; P_VLD holds its value, so a strobe is extended while CE is low. Callers qualify P_VLD with CE.
- RST mid-frame: frame is abandoned; no P_VLD is produced for in-flight samples.
- Throughput: one sample per CE cycle, no back-pressure.

Decomposition:
- Package mac_pkg holds:
  - default widths (18/18/48);
  - localparam function for latency (N+3, or N+3 minus skew depth when SKEW=0 is still N+3 relative to stage 0);
  - clog2 width-check function.
- Sub-module mac_stage covers the skew delay, CLR-able input registers, product register and cascade adder register.
- mac_chain_sys generates N mac_stage instances, the sideband delay line and the accumulator.

Test Plan:
1. N=4, A={1,2,3,4}, B={5,6,7,8}, VLD_IN=1, ACC_EN=0, one cycle -> P=70 with P_VLD high for exactly one cycle, 7 cycles later; OVF=0.
2. All A=B=-131072 -> P=4*2^34=68719476736; a back-to-back next sample {1,1,1,1}x{1,1,1,1} -> P=4 on the following cycle.
3. ACC_EN=1, three samples of case 1 with FIRST on sample 1 and LAST on sample 3, plus an invalid gap cycle between samples 2 and 3 -> one P_VLD, P=210. Then a FIRST+LAST single sample -> P=70.
4. P_W=38, ACC_EN=1, two samples of all -131072 (sum 2^36 each) -> P wraps to -2^37, OVF=1. Next FIRST frame -> OVF=0.
5. CLR=4'b0100 with case 1 -> P=70-21=49. CE held low for 3 cycles mid-pipeline -> same values, delivered 3 cycles later.
6. RST pulsed mid-frame, asynchronously between edges -> P, P_VLD and OVF are 0 immediately; no strobe for the flushed samples; the next frame is correct.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths, sideband payload and elaboration helpers for the MAC chain.
package mac_pkg;

  localparam int unsigned DEF_N   = 4;
  localparam int unsigned DEF_A_W = 18;
  localparam int unsigned DEF_B_W = 18;
  localparam int unsigned DEF_P_W = 48;

  // Control travelling alongside each sample down to the accumulator.
  typedef struct packed {
    logic vld;
    logic acc_en;
    logic first;
    logic last;
  } sb_t;

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Sample-to-P latency, measured from stage 0 whether or not the chain skews internally.
  function automatic int unsigned mac_latency(input int unsigned n);
    return n + 3;
  endfunction

endpackage

// File: rtl/mac_stage.sv
// One tap: optional skew delay, clearable input regs, product reg, cascade add reg.
module mac_stage
  import mac_pkg::*;
#(
  parameter int unsigned A_W = DEF_A_W,
  parameter int unsigned B_W = DEF_B_W,
  parameter int unsigned P_W = DEF_P_W,
  parameter int unsigned DLY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  input  logic                  clr,
  input  logic signed [P_W-1:0] cas_in,
  output logic signed [P_W-1:0] cas_out
);

  localparam int unsigned M_W = A_W + B_W;

  logic signed [A_W-1:0] a_sk;
  logic signed [B_W-1:0] b_sk;
  logic                  clr_sk;

  if (DLY == 0) begin : g_nodly
    assign a_sk   = a;
    assign b_sk   = b;
    assign clr_sk = clr;
  end else begin : g_dly
    logic signed [A_W-1:0] a_q   [DLY];
    logic signed [B_W-1:0] b_q   [DLY];
    logic                  clr_q [DLY];

    // Skew line: delays this tap's operands so all taps of one sample meet in the cascade.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(DLY); i++) begin
          a_q[i]   <= '0;
          b_q[i]   <= '0;
          clr_q[i] <= 1'b0;
        end
      end else if (ce) begin
        a_q[0]   <= a;
        b_q[0]   <= b;
        clr_q[0] <= clr;
        for (int i = 1; i < int'(DLY); i++) begin
          a_q[i]   <= a_q[i-1];
          b_q[i]   <= b_q[i-1];
          clr_q[i] <= clr_q[i-1];
        end
      end
    end

    assign a_sk   = a_q[DLY-1];
    assign b_sk   = b_q[DLY-1];
    assign clr_sk = clr_q[DLY-1];
  end

  logic signed [A_W-1:0] a_r;
  logic signed [B_W-1:0] b_r;
  logic signed [M_W-1:0] prod_c;
  logic signed [P_W-1:0] m_q;

  assign prod_c = M_W'(a_r) * M_W'(b_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      m_q     <= '0;
      cas_out <= '0;
    end else if (ce) begin
      if (clr_sk) begin
        a_r <= '0;
        b_r <= '0;
      end else begin
        a_r <= a_sk;
        b_r <= b_sk;
      end
      m_q     <= P_W'(prod_c);
      cas_out <= m_q + cas_in;
    end
  end

endmodule

// File: rtl/mac_chain_sys.sv
// Systolic sum-of-products chain with aligned sideband and optional frame accumulator.
module mac_chain_sys
  import mac_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned A_W  = DEF_A_W,
  parameter int unsigned B_W  = DEF_B_W,
  parameter int unsigned P_W  = DEF_P_W,
  parameter int unsigned SKEW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic [N*A_W-1:0]      A,
  input  logic [N*B_W-1:0]      B,
  input  logic [N-1:0]          CLR,
  input  logic                  VLD_IN,
  input  logic                  ACC_EN,
  input  logic                  FIRST,
  input  logic                  LAST,
  output logic signed [P_W-1:0] P,
  output logic                  P_VLD,
  output logic                  OVF
);

  localparam int unsigned LAT  = mac_latency(N);
  localparam int unsigned SB_D = LAT - 1;

  if (N < 1 || N > 16) begin : g_bad_n
    $error("mac_chain_sys: N must be within 1..16");
  end
  if (P_W < A_W + B_W + clog2_u(N)) begin : g_bad_pw
    $error("mac_chain_sys: P_W too narrow for A_W+B_W+clog2(N)");
  end

  logic signed [P_W-1:0] cas [N+1];
  assign cas[0] = '0;

  for (genvar k = 0; k < int'(N); k++) begin : g_stage
    mac_stage #(
      .A_W (A_W),
      .B_W (B_W),
      .P_W (P_W),
      .DLY ((SKEW != 0) ? k : 0)
    ) u_stage (
      .clk     (CLK),
      .rst     (RST),
      .ce      (CE),
      .a       (A[k*A_W +: A_W]),
      .b       (B[k*B_W +: B_W]),
      .clr     (CLR[k]),
      .cas_in  (cas[k]),
      .cas_out (cas[k+1])
    );
  end

  sb_t sb_in_c;
  sb_t sb_q [SB_D];
  sb_t sb_acc;

  assign sb_in_c = '{vld: VLD_IN, acc_en: ACC_EN, first: FIRST, last: LAST};

  // Sideband delay line, matched to the chain so it lands with the final cascade sum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(SB_D); i++) sb_q[i] <= '0;
    end else if (CE) begin
      sb_q[0] <= sb_in_c;
      for (int i = 1; i < int'(SB_D); i++) sb_q[i] <= sb_q[i-1];
    end
  end

  assign sb_acc = sb_q[SB_D-1];

  logic signed [P_W-1:0] sum_c;
  logic signed [P_W-1:0] acc_c;
  logic                  add_ovf_c;
  logic signed [P_W-1:0] p_n;
  logic                  ovf_n;
  logic                  vld_n;

  assign sum_c     = cas[N];
  assign acc_c     = P + sum_c;
  assign add_ovf_c = (P[P_W-1] == sum_c[P_W-1]) && (acc_c[P_W-1] != P[P_W-1]);

  // Accumulator next state: pass-through, frame start, or wrapping accumulate.
  always_comb begin
    p_n   = P;
    ovf_n = OVF;
    vld_n = 1'b0;
    if (sb_acc.vld) begin
      if (!sb_acc.acc_en) begin
        p_n   = sum_c;
        ovf_n = 1'b0;
        vld_n = 1'b1;
      end else begin
        if (sb_acc.first) begin
          p_n   = sum_c;
          ovf_n = 1'b0;
        end else begin
          p_n   = acc_c;
          ovf_n = OVF | add_ovf_c;
        end
        vld_n = sb_acc.last;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P     <= '0;
      P_VLD <= 1'b0;
      OVF   <= 1'b0;
    end else if (CE) begin
      P     <= p_n;
      P_VLD <= vld_n;
      OVF   <= ovf_n;
    end
  end

endmodule
